// File: rtl/md_pkg.sv
// Shared definitions for the M-extension issue path: FSM state encoding,
// funct3 opcodes and the divide-by-zero result helpers.
package md_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Any divide or remainder whose divisor is zero.
    function automatic logic is_divzero(input logic [2:0] funct3, input logic [31:0] rs2);
        return funct3[2] && (rs2 == 32'd0);
    endfunction

    // RISC-V divide-by-zero result: remainder returns the dividend, quotient all ones.
    function automatic logic [31:0] divzero_result(input logic [2:0] funct3, input logic [31:0] rs1);
        return ((funct3 == F3_REM) || (funct3 == F3_REMU)) ? rs1 : 32'hFFFF_FFFF;
    endfunction

endpackage

// File: rtl/md_issue_ctrl.sv
// Issue controller for the multiply/divide unit: latch one M instruction, pulse
// the unit, wait out its busy flag, hand the result to writeback. Optional
// MD_DIVZERO_BYPASS_EN resolves divide-by-zero without starting the unit.
module md_issue_ctrl
    import md_pkg::*;
(
    input  logic        i_clk_n,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_rs1,
    input  logic [31:0] i_req_rs2,
    input  logic [4:0]  i_req_rd,
    output logic [31:0] o_md_a,
    output logic [31:0] o_md_b,
    output logic [2:0]  o_md_funct3,
    output logic        o_md_en,
    input  logic [31:0] i_md_result,
    input  logic        i_md_busy,
    output logic        o_wb_valid,
    input  logic        i_wb_ready,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_busy
);

    // Handshakes: a request transfers on a rising edge where i_req_valid and
    // o_req_ready are both high; a result transfers on an edge where o_wb_valid
    // and i_wb_ready are both high. Neither valid depends on its ready.

    md_state_e   state_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic [31:0] data_q;
    logic        md_en_q;
    logic        wb_valid_q;
    logic        req_ready_q;
    logic        busy_q;

    always_ff @(posedge i_clk_n) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            funct3_q    <= '0;
            rd_q        <= '0;
            data_q      <= '0;
            md_en_q     <= 1'b0;
            wb_valid_q  <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            md_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        a_q         <= i_req_rs1;
                        b_q         <= i_req_rs2;
                        funct3_q    <= i_req_funct3;
                        rd_q        <= i_req_rd;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
`ifdef MD_DIVZERO_BYPASS_EN
                        if (is_divzero(i_req_funct3, i_req_rs2)) begin
                            data_q     <= divzero_result(i_req_funct3, i_req_rs1);
                            wb_valid_q <= 1'b1;
                            state_q    <= ST_DONE;
                        end else
`endif
                        begin
                            md_en_q <= 1'b1;
                            state_q <= ST_START;
                        end
                    end
                end
                // The unit raises busy only after the enable edge, so START never looks at it.
                ST_START: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!i_md_busy) begin
                        data_q     <= i_md_result;
                        wb_valid_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_wb_ready) begin
                        wb_valid_q  <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Operands are driven straight from the latches; the unit reads them live until capture.
    assign o_md_a      = a_q;
    assign o_md_b      = b_q;
    assign o_md_funct3 = funct3_q;
    assign o_md_en     = md_en_q;
    assign o_wb_valid  = wb_valid_q;
    assign o_wb_rd     = rd_q;
    assign o_wb_data   = data_q;
    assign o_req_ready = req_ready_q;
    assign o_busy      = busy_q;

endmodule
